// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
//   Shares the register file's single write port (A3/WD3/WE3) and the A2 read
//   address between core writeback, a debug access port and an internal clear
//   sequencer that zeroes every register. Architectural writes to x0 are dropped.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   core_*_i / core_stall_o  core writeback request, rs2 address, stall back to the core
//   dbg_w*                   debug write channel (valid/ready)
//   dbg_r*                   debug read channel (valid/ready), read data with a valid pulse
//   clear_start_i            start clear sweep; clear_busy_o / clear_done_o report progress
//   rf_a3_o/rf_wd3_o/rf_we3_o/rf_a2_o/rf_rd2_i   register file connection
//
// Optional build macro
//   REGFILE_ARB_STARVE_GUARD_EN  forces a debug write grant after STARVE_LIMIT refused cycles.
module regfile_port_arbiter #(
  parameter int unsigned NREGS        = 32,
  parameter int unsigned AW           = 5,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          core_we_i,
  input  logic [AW-1:0] core_wa_i,
  input  logic [31:0]   core_wd_i,
  input  logic [AW-1:0] core_a2_i,
  input  logic          core_a2_used_i,
  output logic          core_stall_o,
  input  logic          dbg_wvalid_i,
  output logic          dbg_wready_o,
  input  logic [AW-1:0] dbg_wa_i,
  input  logic [31:0]   dbg_wd_i,
  input  logic          dbg_rvalid_i,
  output logic          dbg_rready_o,
  input  logic [AW-1:0] dbg_ra_i,
  output logic [31:0]   dbg_rdata_o,
  output logic          dbg_rdata_valid_o,
  input  logic          clear_start_i,
  output logic          clear_busy_o,
  output logic          clear_done_o,
  output logic [AW-1:0] rf_a3_o,
  output logic [31:0]   rf_wd3_o,
  output logic          rf_we3_o,
  output logic [AW-1:0] rf_a2_o,
  input  logic [31:0]   rf_rd2_i
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          done_q, done_d;

  logic in_idle, in_clear, force_dbg, dbg_whs, dbg_rhs, last_addr;

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q, starve_d;
`endif

  assign in_idle   = (state_q == StIdle);
  assign in_clear  = (state_q == StClear);
  assign last_addr = (cnt_q == AW'(NREGS - 1));

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  assign force_dbg = in_idle & (starve_q >= SW'(STARVE_LIMIT));
`else
  assign force_dbg = 1'b0;
`endif

  // Every combinational output is held at 0 while reset is asserted.
  assign dbg_wready_o = rst_ni & in_idle & (~core_we_i | force_dbg);
  assign dbg_rready_o = rst_ni & in_idle & ~core_a2_used_i;
  assign core_stall_o = rst_ni & (in_clear | force_dbg);
  assign rf_a2_o      = !rst_ni ? '0 : ((core_a2_used_i | in_clear) ? core_a2_i : dbg_ra_i);

  assign dbg_whs = dbg_wvalid_i & dbg_wready_o;
  assign dbg_rhs = dbg_rvalid_i & dbg_rready_o;

  // Write-port grant: sweep, then forced/idle debug, then core. x0 writes dropped.
  always_comb begin
    rf_we3_o = 1'b0;
    rf_a3_o  = '0;
    rf_wd3_o = '0;
    if (rst_ni) begin
      if (in_clear) begin
        rf_we3_o = 1'b1;
        rf_a3_o  = cnt_q;
      end else if (dbg_whs) begin
        if (dbg_wa_i != '0) begin
          rf_we3_o = 1'b1;
          rf_a3_o  = dbg_wa_i;
          rf_wd3_o = dbg_wd_i;
        end
      end else if (core_we_i && !force_dbg && core_wa_i != '0) begin
        rf_we3_o = 1'b1;
        rf_a3_o  = core_wa_i;
        rf_wd3_o = core_wd_i;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    rvalid_d = dbg_rhs;
    if (dbg_rhs) begin
      rdata_d = rf_rd2_i;
    end
    unique case (state_q)
      StIdle: begin
        if (clear_start_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (last_addr) begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  // Counts idle cycles in which a pending debug write is refused.
  always_comb begin
    starve_d = starve_q;
    if (in_idle) begin
      if (force_dbg || dbg_whs) begin
        starve_d = '0;
      end else if (dbg_wvalid_i && !dbg_wready_o) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  assign dbg_rdata_o       = rdata_q;
  assign dbg_rdata_valid_o = rvalid_q;
  assign clear_busy_o      = in_clear;
  assign clear_done_o      = done_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          core_we, core_a2_used, core_stall;
  logic [AW-1:0] core_wa, core_a2;
  logic [31:0]   core_wd;
  logic          dbg_wvalid, dbg_wready, dbg_rvalid, dbg_rready, dbg_rdata_valid;
  logic [AW-1:0] dbg_wa, dbg_ra;
  logic [31:0]   dbg_wd, dbg_rdata;
  logic          clear_start, clear_busy, clear_done;
  logic [AW-1:0] rf_a3, rf_a2;
  logic [31:0]   rf_wd3, rf_rd2;
  logic          rf_we3;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] rf_mem [32];
  logic [31:0] shadow [32];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  regfile_port_arbiter dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .core_we_i        (core_we),
    .core_wa_i        (core_wa),
    .core_wd_i        (core_wd),
    .core_a2_i        (core_a2),
    .core_a2_used_i   (core_a2_used),
    .core_stall_o     (core_stall),
    .dbg_wvalid_i     (dbg_wvalid),
    .dbg_wready_o     (dbg_wready),
    .dbg_wa_i         (dbg_wa),
    .dbg_wd_i         (dbg_wd),
    .dbg_rvalid_i     (dbg_rvalid),
    .dbg_rready_o     (dbg_rready),
    .dbg_ra_i         (dbg_ra),
    .dbg_rdata_o      (dbg_rdata),
    .dbg_rdata_valid_o(dbg_rdata_valid),
    .clear_start_i    (clear_start),
    .clear_busy_o     (clear_busy),
    .clear_done_o     (clear_done),
    .rf_a3_o          (rf_a3),
    .rf_wd3_o         (rf_wd3),
    .rf_we3_o         (rf_we3),
    .rf_a2_o          (rf_a2),
    .rf_rd2_i         (rf_rd2)
  );

  // Register file model: synchronous write, asynchronous read.
  always @(posedge clk) if (rf_we3) rf_mem[rf_a3] <= rf_wd3;
  assign rf_rd2 = rf_mem[rf_a2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard: each debug read data pulse pops the next expected value.
  always @(negedge clk) begin
    if (rst_ni && dbg_rdata_valid) begin
      if (exp_q.size() == 0) begin
        chk("rdata_unexpected", 32'(dbg_rdata_valid), 32'd0);
      end else begin
        chk("rdata_sb", dbg_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic read_all();
    for (int i = 0; i < 32; i++) begin
      dbg_rvalid = 1'b1;
      dbg_ra     = AW'(i);
      exp_q.push_back(shadow[i]);
      cyc();
    end
    dbg_rvalid = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic preload(input logic [31:0] base);
    for (int i = 1; i < 32; i++) begin
      core_we   = 1'b1;
      core_wa   = AW'(i);
      core_wd   = base + 32'(i) * 32'h0101;
      shadow[i] = core_wd;
      cyc();
    end
    core_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 32'h0;
      shadow[i] = 32'h0;
    end
    rst_ni = 1'b0;
    core_we = 1'b0; core_wa = '0; core_wd = '0; core_a2 = '0; core_a2_used = 1'b0;
    dbg_wvalid = 1'b0; dbg_wa = '0; dbg_wd = '0; dbg_rvalid = 1'b0; dbg_ra = '0;
    clear_start = 1'b0;

    // Reset state
    #2;
    chk("rst_busy",   32'(clear_busy), 32'd0);
    chk("rst_done",   32'(clear_done), 32'd0);
    chk("rst_rdata",  dbg_rdata, 32'd0);
    chk("rst_rvalid", 32'(dbg_rdata_valid), 32'd0);
    chk("rst_wready", 32'(dbg_wready), 32'd0);
    chk("rst_we3",    32'(rf_we3), 32'd0);
    cyc();
    rst_ni = 1'b1;

    // Core write to x5, read back on A2 next cycle
    core_we = 1'b1; core_wa = 5'd5; core_wd = 32'hDEADBEEF; dbg_wvalid = 1'b1; dbg_wa = 5'd9;
    mid();
    chk("core_we3",    32'(rf_we3), 32'd1);
    chk("core_a3",     32'(rf_a3), 32'd5);
    chk("core_wd3",    rf_wd3, 32'hDEADBEEF);
    chk("core_wready", 32'(dbg_wready), 32'd0);
    chk("core_stall",  32'(core_stall), 32'd0);
    shadow[5] = 32'hDEADBEEF;
    cyc();
    core_we = 1'b0; dbg_wvalid = 1'b0; core_a2 = 5'd5; core_a2_used = 1'b1;
    dbg_rvalid = 1'b1; dbg_ra = 5'd7;
    mid();
    chk("a2_core",   32'(rf_a2), 32'd5);
    chk("rd2_core",  rf_rd2, 32'hDEADBEEF);
    chk("rready_a2", 32'(dbg_rready), 32'd0);
    cyc();
    dbg_rvalid = 1'b0; core_a2_used = 1'b0;

    // Core write to x0 is dropped and still uses the slot
    core_we = 1'b1; core_wa = 5'd0; core_wd = 32'h1234; dbg_wvalid = 1'b1; dbg_wa = 5'd9;
    mid();
    chk("x0_we3",    32'(rf_we3), 32'd0);
    chk("x0_wready", 32'(dbg_wready), 32'd0);
    cyc();
    core_we = 1'b0; dbg_wvalid = 1'b0;
    dbg_rvalid = 1'b1; dbg_ra = 5'd0;
    exp_q.push_back(32'h0);
    mid();
    chk("x0_rready", 32'(dbg_rready), 32'd1);
    cyc();
    dbg_rvalid = 1'b0;

    // Debug write to x7, then debug read with latency 1
    dbg_wvalid = 1'b1; dbg_wa = 5'd7; dbg_wd = 32'hA5A5A5A5;
    mid();
    chk("dbgw_wready", 32'(dbg_wready), 32'd1);
    chk("dbgw_we3",    32'(rf_we3), 32'd1);
    chk("dbgw_a3",     32'(rf_a3), 32'd7);
    chk("dbgw_wd3",    rf_wd3, 32'hA5A5A5A5);
    shadow[7] = 32'hA5A5A5A5;
    cyc();
    dbg_wvalid = 1'b0; dbg_rvalid = 1'b1; dbg_ra = 5'd7;
    exp_q.push_back(32'hA5A5A5A5);
    mid();
    chk("dbgr_a2",     32'(rf_a2), 32'd7);
    chk("dbgr_rvalid0", 32'(dbg_rdata_valid), 32'd0);
    cyc();
    dbg_rvalid = 1'b0;
    mid();
    chk("dbgr_rvalid1", 32'(dbg_rdata_valid), 32'd1);
    chk("dbgr_rdata",   dbg_rdata, 32'hA5A5A5A5);
    cyc();
    mid();
    chk("dbgr_rvalid2", 32'(dbg_rdata_valid), 32'd0);
    chk("dbgr_hold",    dbg_rdata, 32'hA5A5A5A5);
    cyc();

    // Same-cycle write and read of x7 returns the old value
    dbg_wvalid = 1'b1; dbg_wa = 5'd7; dbg_wd = 32'h5555AAAA;
    dbg_rvalid = 1'b1; dbg_ra = 5'd7;
    exp_q.push_back(32'hA5A5A5A5);
    shadow[7] = 32'h5555AAAA;
    cyc();
    // Debug write to x0: accepted but dropped
    dbg_wa = 5'd0; dbg_wd = 32'hFFFF0000; dbg_rvalid = 1'b0;
    mid();
    chk("dbgx0_wready", 32'(dbg_wready), 32'd1);
    chk("dbgx0_we3",    32'(rf_we3), 32'd0);
    cyc();
    dbg_wvalid = 1'b0;

    // Preload, then full clear sweep
    preload(32'h1000_0000);
    read_all();
    clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    dbg_wvalid = 1'b1; dbg_wa = 5'd4; dbg_rvalid = 1'b1; core_we = 1'b1; core_wa = 5'd6;
    for (int i = 0; i < 32; i++) begin
      clear_start = (i == 5);
      mid();
      chk("clr_busy",   32'(clear_busy), 32'd1);
      chk("clr_stall",  32'(core_stall), 32'd1);
      chk("clr_we3",    32'(rf_we3), 32'd1);
      chk("clr_a3",     32'(rf_a3), 32'(i));
      chk("clr_wd3",    rf_wd3, 32'd0);
      chk("clr_wready", 32'(dbg_wready), 32'd0);
      chk("clr_rready", 32'(dbg_rready), 32'd0);
      chk("clr_done0",  32'(clear_done), 32'd0);
      cyc();
    end
    clear_start = 1'b0; dbg_wvalid = 1'b0; dbg_rvalid = 1'b0; core_we = 1'b0;
    for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
    mid();
    chk("clr_end_busy", 32'(clear_busy), 32'd0);
    chk("clr_end_done", 32'(clear_done), 32'd1);
    cyc();
    mid();
    chk("clr_done_pulse", 32'(clear_done), 32'd0);
    cyc();
    read_all();

    // Reset during sweep cycle 10
    preload(32'h2000_0000);
    clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    for (int i = 0; i < 10; i++) shadow[i] = 32'h0;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(clear_busy), 32'd0);
    chk("mid_rst_we3",  32'(rf_we3), 32'd0);
    chk("mid_rst_done", 32'(clear_done), 32'd0);
    cyc();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("mid_rst_nodone", 32'(clear_done), 32'd0);
      cyc();
    end
    read_all();

    // Debug starvation under continuous core writes
    core_we = 1'b1; core_wa = 5'd3; core_wd = 32'h0BAD_F00D;
    dbg_wvalid = 1'b1; dbg_wa = 5'd9; dbg_wd = 32'hCAFE_0009;
`ifdef REGFILE_ARB_STARVE_GUARD_EN
    for (int k = 1; k <= 9; k++) begin
      mid();
      if (k < 9) begin
        chk("stv_wready", 32'(dbg_wready), 32'd0);
        chk("stv_stall",  32'(core_stall), 32'd0);
        shadow[3] = 32'h0BAD_F00D;
      end else begin
        chk("stv_force_wready", 32'(dbg_wready), 32'd1);
        chk("stv_force_stall",  32'(core_stall), 32'd1);
        chk("stv_force_a3",     32'(rf_a3), 32'd9);
        shadow[9] = 32'hCAFE_0009;
      end
      cyc();
    end
`else
    for (int k = 1; k <= 100; k++) begin
      mid();
      chk("stv_wready", 32'(dbg_wready), 32'd0);
      chk("stv_stall",  32'(core_stall), 32'd0);
      cyc();
    end
    shadow[3] = 32'h0BAD_F00D;
`endif
    core_we = 1'b0; dbg_wvalid = 1'b0;
    read_all();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
